dp_ram_pipe: RTL and testbench

Parametrised true dual-port byte-writable RAM that succeeds the single-latency dual-port RAM used by the accelerator buffers. It adds a configurable read pipeline (1-4 cycles), a selectable read-during-write mode and deterministic write-collision arbitration. Each port carries a tagged read acknowledge. Sits between the RISC-V bus bridge (port A) and the accelerator datapath (port B).

---
 rtl/dp_ram_pipe.sv | 159 +++++++++++++++
 tb/tb_dp_ram_pipe.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_ram_pipe.sv
// dp_ram_pipe: true dual-port byte-writable RAM, 1-4 cycle read pipeline.
// Define DP_RAM_PIPE_COLLISION_EN to add the collision pulse and counter.
module dp_ram_pipe #(
  parameter int DATA_WIDTH   = 32,
  parameter int RAM_DEPTH    = 512,
  parameter int READ_LATENCY = 1,
  parameter int RD_MODE      = 0,
  localparam int WREN_WIDTH  = (DATA_WIDTH + 7) / 8,
  localparam int ADDR_WIDTH  = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
  input  logic                  clkIn,
  input  logic                  rstNIn,
  input  logic [ADDR_WIDTH-1:0] addrAIn,
  input  logic [WREN_WIDTH-1:0] wrEnAIn,
  input  logic [DATA_WIDTH-1:0] wrDataAIn,
  input  logic                  rdEnAIn,
  output logic [DATA_WIDTH-1:0] rdDataAOut,
  output logic                  rdAckAOut,
  input  logic [ADDR_WIDTH-1:0] addrBIn,
  input  logic [WREN_WIDTH-1:0] wrEnBIn,
  input  logic [DATA_WIDTH-1:0] wrDataBIn,
  input  logic                  rdEnBIn,
  output logic [DATA_WIDTH-1:0] rdDataBOut,
  output logic                  rdAckBOut
`ifdef DP_RAM_PIPE_COLLISION_EN
  ,
  output logic                  collisionOut,
  output logic [15:0]           collisionCntOut
`endif
);

  localparam int PAD_WIDTH = WREN_WIDTH * 8;
  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH + 1)'(RAM_DEPTH);

  typedef logic [PAD_WIDTH-1:0] word_t;

  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $fatal(1, "dp_ram_pipe: READ_LATENCY must be 1..4");
  end

  word_t mem [RAM_DEPTH];

  logic in_a;
  logic in_b;
  logic same;
  word_t wd_a;
  word_t wd_b;
  word_t rd_a;
  word_t rd_b;
  logic [WREN_WIDTH-1:0] we_a;
  logic [WREN_WIDTH-1:0] we_b;
  logic [DATA_WIDTH-1:0] rd_data_a;
  logic [DATA_WIDTH-1:0] rd_data_b;

  assign in_a = {1'b0, addrAIn} < DEPTH;
  assign in_b = {1'b0, addrBIn} < DEPTH;
  assign same = addrAIn == addrBIn;
  assign wd_a = word_t'(wrDataAIn);
  assign wd_b = word_t'(wrDataBIn);

  // port A owns every lane it enables on a shared address
  assign we_a = (in_a && rstNIn) ? wrEnAIn : '0;
  assign we_b = (in_b && rstNIn) ?
                (wrEnBIn & ~(same ? wrEnAIn : '0)) : '0;

  function automatic word_t merge(
    input word_t old,
    input word_t wd,
    input logic [WREN_WIDTH-1:0] en
  );
    word_t r;
    r = old;
    for (int i = 0; i < WREN_WIDTH; i++) begin
      if (en[i]) r[i*8 +: 8] = wd[i*8 +: 8];
    end
    return r;
  endfunction

  always_comb begin
    rd_a = '0;
    rd_b = '0;
    if (in_a) begin
      rd_a = mem[addrAIn];
      if (RD_MODE == 1) rd_a = merge(rd_a, wd_a, wrEnAIn);
    end
    if (in_b) begin
      rd_b = mem[addrBIn];
      if (RD_MODE == 1) rd_b = merge(rd_b, wd_b, wrEnBIn);
    end
  end

  assign rd_data_a = rd_a[DATA_WIDTH-1:0];
  assign rd_data_b = rd_b[DATA_WIDTH-1:0];

  always_ff @(posedge clkIn) begin
    for (int i = 0; i < WREN_WIDTH; i++) begin
      if (we_a[i]) mem[addrAIn][i*8 +: 8] <= wd_a[i*8 +: 8];
      if (we_b[i]) mem[addrBIn][i*8 +: 8] <= wd_b[i*8 +: 8];
    end
  end

  logic [READ_LATENCY-1:0] ack_a;
  logic [READ_LATENCY-1:0] ack_b;
  logic [DATA_WIDTH-1:0]   pipe_a [READ_LATENCY];
  logic [DATA_WIDTH-1:0]   pipe_b [READ_LATENCY];

  // data stages only advance behind a valid ack
  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      ack_a <= '0;
      ack_b <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_a[i] <= '0;
        pipe_b[i] <= '0;
      end
    end else begin
      ack_a[0] <= rdEnAIn;
      ack_b[0] <= rdEnBIn;
      if (rdEnAIn) pipe_a[0] <= rd_data_a;
      if (rdEnBIn) pipe_b[0] <= rd_data_b;
      for (int i = 1; i < READ_LATENCY; i++) begin
        ack_a[i] <= ack_a[i-1];
        ack_b[i] <= ack_b[i-1];
        if (ack_a[i-1]) pipe_a[i] <= pipe_a[i-1];
        if (ack_b[i-1]) pipe_b[i] <= pipe_b[i-1];
      end
    end
  end

  assign rdAckAOut  = ack_a[READ_LATENCY-1];
  assign rdAckBOut  = ack_b[READ_LATENCY-1];
  assign rdDataAOut = pipe_a[READ_LATENCY-1];
  assign rdDataBOut = pipe_b[READ_LATENCY-1];

`ifdef DP_RAM_PIPE_COLLISION_EN
  logic hit;
  logic coll_q;
  logic [15:0] cnt_q;

  assign hit = same &&
               ((|(wrEnAIn & wrEnBIn)) ||
                (rdEnAIn && (|wrEnBIn)) ||
                (rdEnBIn && (|wrEnAIn)));

  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      coll_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      coll_q <= hit;
      if (hit && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
    end
  end

  assign collisionOut    = coll_q;
  assign collisionCntOut = cnt_q;
`endif

endmodule

// File: tb/tb_dp_ram_pipe.sv
// tb_dp_ram_pipe: two dp_ram_pipe builds on shared stimulus,
// checked every cycle against a schedule-based reference model.
module tb_dp_ram_pipe;

  localparam int NCYC = 1400;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic [8:0]  addr [2];
  logic [3:0]  wen  [2];
  logic [31:0] wdat [2];
  logic        ren  [2];

  logic [31:0] rdat [2][2];
  logic        ack  [2][2];
`ifdef DP_RAM_PIPE_COLLISION_EN
  logic        col  [2];
  logic [15:0] cnt  [2];
`endif

  dp_ram_pipe #(
    .DATA_WIDTH(32), .RAM_DEPTH(500),
    .READ_LATENCY(3), .RD_MODE(0)
  ) dut0 (
    .clkIn(clk), .rstNIn(rstn),
    .addrAIn(addr[0]), .wrEnAIn(wen[0]),
    .wrDataAIn(wdat[0]), .rdEnAIn(ren[0]),
    .rdDataAOut(rdat[0][0]), .rdAckAOut(ack[0][0]),
    .addrBIn(addr[1]), .wrEnBIn(wen[1]),
    .wrDataBIn(wdat[1]), .rdEnBIn(ren[1]),
    .rdDataBOut(rdat[0][1]), .rdAckBOut(ack[0][1])
`ifdef DP_RAM_PIPE_COLLISION_EN
    , .collisionOut(col[0]), .collisionCntOut(cnt[0])
`endif
  );

  dp_ram_pipe #(
    .DATA_WIDTH(32), .RAM_DEPTH(512),
    .READ_LATENCY(4), .RD_MODE(1)
  ) dut1 (
    .clkIn(clk), .rstNIn(rstn),
    .addrAIn(addr[0]), .wrEnAIn(wen[0]),
    .wrDataAIn(wdat[0]), .rdEnAIn(ren[0]),
    .rdDataAOut(rdat[1][0]), .rdAckAOut(ack[1][0]),
    .addrBIn(addr[1]), .wrEnBIn(wen[1]),
    .wrDataBIn(wdat[1]), .rdEnBIn(ren[1]),
    .rdDataBOut(rdat[1][1]), .rdAckBOut(ack[1][1])
`ifdef DP_RAM_PIPE_COLLISION_EN
    , .collisionOut(col[1]), .collisionCntOut(cnt[1])
`endif
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [31:0] mmem [2][512];
  bit          sa   [2][2][NCYC];
  logic [31:0] sd   [2][2][NCYC];
  logic [31:0] held [2][2];
  logic        ecol;
  logic [15:0] ecnt;

  function automatic int depth_of(int k);
    return (k == 0) ? 500 : 512;
  endfunction

  function automatic int lat_of(int k);
    return (k == 0) ? 3 : 4;
  endfunction

  function automatic int mode_of(int k);
    return (k == 0) ? 0 : 1;
  endfunction

  function automatic logic [31:0] rd_word(int k, int p);
    logic [31:0] w;
    if (int'(addr[p]) >= depth_of(k)) return 32'h0;
    w = mmem[k][addr[p]];
    if (mode_of(k) == 1)
      for (int i = 0; i < 4; i++)
        if (wen[p][i]) w[i*8 +: 8] = wdat[p][i*8 +: 8];
    return w;
  endfunction

  function automatic logic coll_hit();
    return (addr[0] == addr[1]) &&
           ((|(wen[0] & wen[1])) ||
            (ren[0] && (|wen[1])) ||
            (ren[1] && (|wen[0])));
  endfunction

  task automatic check_eq(string tag, logic [31:0] obs,
                          logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check();
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 2; p++) begin
        if (sa[k][p][cyc]) held[k][p] = sd[k][p][cyc];
        check_eq($sformatf("ack%0d%s", k, p ? "B" : "A"),
                 32'(ack[k][p]), 32'(sa[k][p][cyc]));
        check_eq($sformatf("data%0d%s", k, p ? "B" : "A"),
                 rdat[k][p], held[k][p]);
      end
`ifdef DP_RAM_PIPE_COLLISION_EN
      check_eq($sformatf("coll%0d", k), 32'(col[k]), 32'(ecol));
      check_eq($sformatf("ccnt%0d", k), 32'(cnt[k]), 32'(ecnt));
`endif
    end
  endtask

  task automatic tick();
    logic hit;
    hit = rstn && coll_hit();
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < 2; p++)
        if (rstn && ren[p]) begin
          sa[k][p][cyc + lat_of(k)] = 1'b1;
          sd[k][p][cyc + lat_of(k)] = rd_word(k, p);
        end
    @(posedge clk);
    if (rstn) begin
      // port A applied last, so it owns any lane both ports enable
      for (int k = 0; k < 2; k++)
        for (int p = 1; p >= 0; p--)
          if (int'(addr[p]) < depth_of(k))
            for (int i = 0; i < 4; i++)
              if (wen[p][i])
                mmem[k][addr[p]][i*8 +: 8] = wdat[p][i*8 +: 8];
      ecol = hit;
      if (hit && ecnt != 16'hFFFF) ecnt = ecnt + 16'd1;
    end
    cyc++;
    @(negedge clk);
    check();
  endtask

  task automatic set(int p, int a, logic [3:0] we,
                     logic [31:0] d, logic re);
    addr[p] = 9'(a);
    wen[p]  = we;
    wdat[p] = d;
    ren[p]  = re;
  endtask

  task automatic idle(int n);
    set(0, 0, 4'h0, 32'h0, 1'b0);
    set(1, 0, 4'h0, 32'h0, 1'b0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < 2; p++) begin
        held[k][p] = 32'h0;
        for (int c = cyc; c <= cyc + 4; c++) sa[k][p][c] = 1'b0;
      end
    ecol = 1'b0;
    ecnt = 16'h0;
    check();
    tick();
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0;
    for (int p = 0; p < 2; p++) set(p, 0, 4'h0, 32'h0, 1'b0);
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < 2; p++) begin
        held[k][p] = 32'h0;
        for (int c = 0; c < NCYC; c++) begin
          sa[k][p][c] = 1'b0;
          sd[k][p][c] = 32'h0;
        end
      end
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 512; a++) mmem[k][a] = 32'h0;
    ecol = 1'b0;
    ecnt = 16'h0;

    #1;
    check();
    @(negedge clk);
    tick();
    tick();
    rstn = 1'b1;

    // clear the array so later directed checks start from zero
    for (int a = 0; a < 256; a++) begin
      set(0, a, 4'hF, 32'h0, 1'b0);
      set(1, a + 256, 4'hF, 32'h0, 1'b0);
      tick();
    end
    idle(1);

    // full-word write then a single read, held after the ack
    set(0, 5, 4'hF, 32'hDEADBEEF, 1'b0);
    tick();
    set(0, 5, 4'h0, 32'h0, 1'b1);
    tick();
    idle(5);
    check_eq("t1_hold0", rdat[0][0], 32'hDEADBEEF);
    check_eq("t1_hold1", rdat[1][0], 32'hDEADBEEF);

    // write-write collision with overlapping lane 1
    set(0, 9, 4'b0011, 32'h11223344, 1'b0);
    set(1, 9, 4'b0110, 32'hAABBCCDD, 1'b0);
    tick();
`ifdef DP_RAM_PIPE_COLLISION_EN
    check_eq("t2_col", 32'(col[0]), 32'h1);
    check_eq("t2_cnt", 32'(cnt[0]), 32'h1);
`endif
    idle(1);
    set(0, 9, 4'h0, 32'h0, 1'b1);
    tick();
    idle(5);
    check_eq("t2_rd0", rdat[0][0], 32'h00BB3344);
    check_eq("t2_rd1", rdat[1][0], 32'h00BB3344);

    // same-port read-during-write
    set(0, 7, 4'b1100, 32'hCAFEF00D, 1'b1);
    tick();
    idle(5);
    check_eq("t3_mode0", rdat[0][0], 32'h0);
    check_eq("t3_mode1", rdat[1][0], 32'hCAFE0000);

    // cross-port read during write sees old data
    set(1, 3, 4'hF, 32'h9, 1'b0);
    tick();
    set(1, 3, 4'hF, 32'h5, 1'b0);
    set(0, 3, 4'h0, 32'h0, 1'b1);
    tick();
    idle(5);
    check_eq("t4_old0", rdat[0][0], 32'h9);
    check_eq("t4_old1", rdat[1][0], 32'h9);
    set(0, 3, 4'h0, 32'h0, 1'b1);
    tick();
    idle(5);
    check_eq("t4_new0", rdat[0][0], 32'h5);
    check_eq("t4_new1", rdat[1][0], 32'h5);

    // reset drops in-flight port B reads
    set(1, 9, 4'h0, 32'h0, 1'b1);
    tick();
    idle(5);
    set(1, 3, 4'h0, 32'h0, 1'b1);
    tick();
    tick();
    do_reset();
    check_eq("t5_rst0", rdat[0][1], 32'h0);
    check_eq("t5_rst1", rdat[1][1], 32'h0);
    idle(6);
    check_eq("t5_noack0", 32'(ack[0][1]), 32'h0);

    // boundary of the 500-word build
    set(0, 499, 4'hF, 32'h12345678, 1'b0);
    set(1, 510, 4'hF, 32'h87654321, 1'b0);
    tick();
    set(0, 499, 4'h0, 32'h0, 1'b1);
    set(1, 510, 4'h0, 32'h0, 1'b1);
    tick();
    idle(5);
    check_eq("t6_in0", rdat[0][0], 32'h12345678);
    check_eq("t6_oor0", rdat[0][1], 32'h0);
    check_eq("t6_in1", rdat[1][1], 32'h87654321);

    // random traffic, small address window plus the top boundary
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < 2; p++) begin
        set(p,
            ($urandom_range(0, 9) == 0) ?
              int'($urandom_range(495, 511)) :
              int'($urandom_range(0, 15)),
            ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0,
            $urandom,
            1'($urandom));
      end
      if ($urandom_range(0, 99) == 0) do_reset();
      else tick();
    end
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
